// File: rtl/frame_comparator.sv
// Dual-channel serial frame capture and word-serial comparison.
// Reports busy/pass/fail status, mismatch bit count and lowest differing bit index.
module frame_comparator #(
    parameter int FRAME_BITS   = 64,
    parameter int WORD_W       = 8,
    parameter int MAX_MISMATCH = 0,
    localparam int CW = $clog2(FRAME_BITS + 1),
    localparam int IW = $clog2(FRAME_BITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_en1,
    input  logic          data_in1,
    input  logic          data_en2,
    input  logic          data_in2,
    input  logic          comp_start_n,
    output logic [1:0]    comp_status,
    output logic [CW-1:0] mismatch_cnt,
    output logic [IW-1:0] first_diff_idx
);

    localparam int NWORDS = FRAME_BITS / WORD_W;
    localparam int PW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] buf1_q, buf1_d, buf2_q, buf2_d;
    logic [CW-1:0]         cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic                  ovf1_q, ovf1_d, ovf2_q, ovf2_d;
    logic [PW-1:0]         word_ptr_q, word_ptr_d;
    logic [CW-1:0]         mismatch_cnt_q, mismatch_cnt_d;
    logic [IW-1:0]         first_diff_idx_q, first_diff_idx_d;
    logic                  diff_seen_q, diff_seen_d;
    logic [1:0]            comp_status_q, comp_status_d;

    logic [IW-1:0]         word_base;
    logic [WORD_W-1:0]     xor_word;
    logic [CW-1:0]         pop_cnt;
    logic [IW-1:0]         low_bit;
    logic [CW-1:0]         mismatch_total;
    logic                  fail;

    always_comb begin
        state_d          = state_q;
        buf1_d           = buf1_q;
        buf2_d           = buf2_q;
        cnt1_d           = cnt1_q;
        cnt2_d           = cnt2_q;
        ovf1_d           = ovf1_q;
        ovf2_d           = ovf2_q;
        word_ptr_d       = word_ptr_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        first_diff_idx_d = first_diff_idx_q;
        diff_seen_d      = diff_seen_q;
        comp_status_d    = comp_status_q;

        word_base = IW'(word_ptr_q) * IW'(WORD_W);
        xor_word  = buf1_q[word_base +: WORD_W] ^ buf2_q[word_base +: WORD_W];
        pop_cnt   = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            pop_cnt = pop_cnt + CW'(xor_word[i]);
        end
        // Descending scan so the lowest set bit is the one left standing.
        low_bit = '0;
        for (int unsigned i = WORD_W; i > 0; i--) begin
            if (xor_word[i-1]) low_bit = IW'(i - 1);
        end
        mismatch_total = mismatch_cnt_q + pop_cnt;
        fail = (cnt1_q != cnt2_q) | ovf1_q | ovf2_q
             | (mismatch_total > CW'(MAX_MISMATCH));

        case (state_q)
            IDLE: begin
                comp_status_d = 2'b10;
                if (data_en1) begin
                    if (cnt1_q == CW'(FRAME_BITS)) begin
                        ovf1_d = 1'b1;
                    end else begin
                        buf1_d[cnt1_q[IW-1:0]] = data_in1;
                        cnt1_d = cnt1_q + 1'b1;
                    end
                end
                if (data_en2) begin
                    if (cnt2_q == CW'(FRAME_BITS)) begin
                        ovf2_d = 1'b1;
                    end else begin
                        buf2_d[cnt2_q[IW-1:0]] = data_in2;
                        cnt2_d = cnt2_q + 1'b1;
                    end
                end
                if (!comp_start_n) begin
                    state_d          = COMPARE;
                    word_ptr_d       = '0;
                    mismatch_cnt_d   = '0;
                    first_diff_idx_d = '0;
                    diff_seen_d      = 1'b0;
                end
            end
            COMPARE: begin
                comp_status_d = 2'b10;
                if (comp_start_n) begin
                    state_d          = IDLE;
                    mismatch_cnt_d   = '0;
                    first_diff_idx_d = '0;
                end else begin
                    mismatch_cnt_d = mismatch_total;
                    if ((xor_word != '0) && !diff_seen_q) begin
                        first_diff_idx_d = word_base + low_bit;
                        diff_seen_d      = 1'b1;
                    end
                    if (word_ptr_q == PW'(NWORDS - 1)) begin
                        state_d       = DONE;
                        comp_status_d = {1'b0, fail};
                    end else begin
                        word_ptr_d = word_ptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (comp_start_n) begin
                    state_d       = IDLE;
                    comp_status_d = 2'b10;
                    buf1_d        = '0;
                    buf2_d        = '0;
                    cnt1_d        = '0;
                    cnt2_d        = '0;
                    ovf1_d        = 1'b0;
                    ovf2_d        = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                comp_status_d = 2'b10;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            buf1_q           <= '0;
            buf2_q           <= '0;
            cnt1_q           <= '0;
            cnt2_q           <= '0;
            ovf1_q           <= 1'b0;
            ovf2_q           <= 1'b0;
            word_ptr_q       <= '0;
            mismatch_cnt_q   <= '0;
            first_diff_idx_q <= '0;
            diff_seen_q      <= 1'b0;
            comp_status_q    <= 2'b10;
        end else begin
            state_q          <= state_d;
            buf1_q           <= buf1_d;
            buf2_q           <= buf2_d;
            cnt1_q           <= cnt1_d;
            cnt2_q           <= cnt2_d;
            ovf1_q           <= ovf1_d;
            ovf2_q           <= ovf2_d;
            word_ptr_q       <= word_ptr_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            first_diff_idx_q <= first_diff_idx_d;
            diff_seen_q      <= diff_seen_d;
            comp_status_q    <= comp_status_d;
        end
    end

    assign comp_status    = comp_status_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_diff_idx = first_diff_idx_q;

endmodule
